// File: rtl/ddr_dly_pkg.sv
// Shared types for the DDR lane delay-line sequencer.
// Request modes, completion status codes and FSM states.
package ddr_dly_pkg;

    typedef enum logic [1:0] {
        DLY_LOAD = 2'b00,
        DLY_ABS  = 2'b01,
        DLY_INC  = 2'b10,
        DLY_DEC  = 2'b11
    } dly_mode_e;

    typedef enum logic [1:0] {
        ST_OK  = 2'b00,
        ST_OOR = 2'b01,
        ST_REJ = 2'b10
    } dly_status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SETUP,
        S_MOVE,
        S_GAP,
        S_FIN
    } dly_state_e;

    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr_lane_tap_bank.sv
// Per-lane shadow tap registers mirroring the IOD delay-line position.
// One indexed read port, one indexed load/inc/dec write port.
module ddr_lane_tap_bank
    import ddr_dly_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int TAP_W     = 8,
    parameter int INIT_TAP  = 1,
    localparam int LW       = min1_clog2(NUM_LANES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LW-1:0]              rd_lane,
    output logic [TAP_W-1:0]           rd_tap,
    input  logic [LW-1:0]              wr_lane,
    input  logic                       wr_load,
    input  logic                       wr_inc,
    input  logic                       wr_dec,
    output logic [NUM_LANES*TAP_W-1:0] tap_cur
);

    logic [NUM_LANES-1:0][TAP_W-1:0] tap_q;
    logic                            rd_ok;
    logic                            wr_ok;

    assign rd_ok   = int'(rd_lane) < NUM_LANES;
    assign wr_ok   = int'(wr_lane) < NUM_LANES;
    assign rd_tap  = rd_ok ? tap_q[rd_lane] : '0;
    assign tap_cur = tap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                tap_q[i] <= TAP_W'(INIT_TAP);
            end
        end else if (wr_ok) begin
            unique case (1'b1)
                wr_load: tap_q[wr_lane] <= TAP_W'(INIT_TAP);
                wr_inc:  tap_q[wr_lane] <= tap_q[wr_lane] + TAP_W'(1);
                wr_dec:  tap_q[wr_lane] <= tap_q[wr_lane] - TAP_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ddr_lane_dly_seq.sv
// IOD delay-line sequencer for DDR4 PHY lanes on the fabric clock.
// Turns load/abs/inc/dec requests into LOAD/MOVE pulses with shadow taps.
module ddr_lane_dly_seq
    import ddr_dly_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int TAP_W     = 8,
    parameter int MAX_TAP   = 255,
    parameter int INIT_TAP  = 1,
    parameter int MOVE_GAP  = 2,
    localparam int LW       = min1_clog2(NUM_LANES)
) (
    input  logic                       FAB_CLK,
    input  logic                       ARST,
    input  logic                       REQ_VALID,
    output logic                       REQ_READY,
    input  logic [LW-1:0]              REQ_LANE,
    input  logic [1:0]                 REQ_MODE,
    input  logic [TAP_W-1:0]           REQ_VALUE,
    output logic                       DONE,
    output logic [LW-1:0]              DONE_LANE,
    output logic [1:0]                 DONE_STATUS,
    output logic                       BUSY,
    output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
    input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_LANES*TAP_W-1:0] TAP_CUR
);

    localparam int GW = min1_clog2(MOVE_GAP);
    localparam int XW = TAP_W + 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(MOVE_GAP - 1);
    localparam logic [XW-1:0] MAX_X    = XW'(MAX_TAP);

    dly_state_e           state_q, state_d;
    dly_mode_e            mode_q, mode_d;
    dly_status_e          status_q, status_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic [TAP_W-1:0]     val_q, val_d;
    logic [TAP_W-1:0]     steps_q, steps_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [NUM_LANES-1:0] dir_q, dir_d;
    logic [NUM_LANES-1:0] lane_oh;

    logic [TAP_W-1:0]     cur;
    logic [TAP_W-1:0]     steps_n;
    logic [XW-1:0]        cur_x, val_x, sum_x;
    logic                 lane_bad, reject, up, dir_n;
    logic                 tap_load, tap_inc, tap_dec;

    ddr_lane_tap_bank #(
        .NUM_LANES (NUM_LANES),
        .TAP_W     (TAP_W),
        .INIT_TAP  (INIT_TAP)
    ) u_bank (
        .clk     (FAB_CLK),
        .rst     (ARST),
        .rd_lane (lane_q),
        .rd_tap  (cur),
        .wr_lane (lane_q),
        .wr_load (tap_load),
        .wr_inc  (tap_inc),
        .wr_dec  (tap_dec),
        .tap_cur (TAP_CUR)
    );

    // Range checks run one bit wider than the tap so cur+VALUE cannot wrap.
    always_comb begin
        cur_x    = {1'b0, cur};
        val_x    = {1'b0, val_q};
        sum_x    = cur_x + val_x;
        lane_bad = int'(lane_q) >= NUM_LANES;
        up       = val_q > cur;
        reject   = lane_bad
                || (mode_q == DLY_ABS && val_x > MAX_X)
                || (mode_q == DLY_INC && sum_x > MAX_X)
                || (mode_q == DLY_DEC && val_x > cur_x);
        steps_n  = val_q;
        dir_n    = 1'b0;
        unique case (1'b1)
            mode_q == DLY_ABS: begin
                steps_n = up ? (val_q - cur) : (cur - val_q);
                dir_n   = up;
            end
            mode_q == DLY_INC: dir_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        status_d = status_q;
        lane_d   = lane_q;
        val_d    = val_q;
        steps_d  = steps_q;
        gap_d    = gap_q;
        dir_d    = dir_q;
        tap_load = 1'b0;
        tap_inc  = 1'b0;
        tap_dec  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (REQ_VALID && !ARST) begin
                    lane_d   = REQ_LANE;
                    mode_d   = dly_mode_e'(REQ_MODE);
                    val_d    = REQ_VALUE;
                    status_d = ST_OK;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (reject) begin
                    status_d = ST_REJ;
                    state_d  = S_FIN;
                end else begin
                    steps_d = steps_n;
                    if (mode_q != DLY_LOAD) begin
                        dir_d[lane_q] = dir_n;
                    end
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                tap_load = mode_q == DLY_LOAD;
                gap_d    = '0;
                state_d  = (tap_load || steps_q == '0) ? S_FIN : S_MOVE;
            end
            S_MOVE: begin
                gap_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q != GAP_LAST) begin
                    gap_d = gap_q + GW'(1);
                end else if (DELAY_LINE_OUT_OF_RANGE[lane_q]) begin
                    status_d = ST_OOR;
                    state_d  = S_FIN;
                end else begin
                    // Commit the step only once the IOD has settled in range.
                    tap_inc = dir_q[lane_q];
                    tap_dec = !dir_q[lane_q];
                    steps_d = steps_q - TAP_W'(1);
                    state_d = (steps_q == TAP_W'(1)) ? S_FIN : S_MOVE;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            mode_q   <= DLY_LOAD;
            status_q <= ST_OK;
            lane_q   <= '0;
            val_q    <= '0;
            steps_q  <= '0;
            gap_q    <= '0;
            dir_q    <= '0;
        end else begin
            mode_q   <= mode_d;
            status_q <= status_d;
            lane_q   <= lane_d;
            val_q    <= val_d;
            steps_q  <= steps_d;
            gap_q    <= gap_d;
            dir_q    <= dir_d;
        end
    end

    assign lane_oh              = NUM_LANES'(1) << lane_q;
    assign REQ_READY            = (state_q == S_IDLE) && !ARST;
    assign BUSY                 = state_q != S_IDLE;
    assign DONE                 = state_q == S_FIN;
    assign DONE_LANE            = DONE ? lane_q : '0;
    assign DONE_STATUS          = DONE ? status_q : ST_OK;
    assign DELAY_LINE_DIRECTION = dir_q;

    assign DELAY_LINE_LOAD = (state_q == S_SETUP && mode_q == DLY_LOAD)
                           ? lane_oh : '0;
    assign DELAY_LINE_MOVE = (state_q == S_MOVE) ? lane_oh : '0;

endmodule

// File: tb/tb_ddr_lane_dly_seq.sv
// Self-checking bench for ddr_lane_dly_seq with a request scoreboard.
// Expected completions are modelled at issue time and popped on DONE.
module tb_ddr_lane_dly_seq;

    localparam int NL   = 4;
    localparam int TW   = 8;
    localparam int MAXT = 255;
    localparam int INIT = 1;
    localparam int GAP  = 2;
    localparam int STEP = GAP + 1;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_lane = '0;
    logic [1:0]    req_mode = '0;
    logic [TW-1:0] req_value = '0;
    logic          done;
    logic [1:0]    done_lane;
    logic [1:0]    done_status;
    logic          busy;
    logic [NL-1:0] ld, mv, dir;
    logic [NL-1:0] oor = '0;
    logic [NL*TW-1:0] tap_cur;

    always #5 clk = ~clk;

    ddr_lane_dly_seq #(
        .NUM_LANES (NL),
        .TAP_W     (TW),
        .MAX_TAP   (MAXT),
        .INIT_TAP  (INIT),
        .MOVE_GAP  (GAP)
    ) dut (
        .FAB_CLK                 (clk),
        .ARST                    (arst),
        .REQ_VALID               (req_valid),
        .REQ_READY               (req_ready),
        .REQ_LANE                (req_lane),
        .REQ_MODE                (req_mode),
        .REQ_VALUE               (req_value),
        .DONE                    (done),
        .DONE_LANE               (done_lane),
        .DONE_STATUS             (done_status),
        .BUSY                    (busy),
        .DELAY_LINE_LOAD         (ld),
        .DELAY_LINE_MOVE         (mv),
        .DELAY_LINE_DIRECTION    (dir),
        .DELAY_LINE_OUT_OF_RANGE (oor),
        .TAP_CUR                 (tap_cur)
    );

    typedef struct {
        int lane;
        int st;
        int lat;
        int nmov;
        int nload;
        int tap;
    } exp_t;

    exp_t exp_q[$];
    int   tap_m[NL];
    int   cmp_n = 0;
    int   bad_n = 0;

    int            done_t, done_st, done_ln, pulse_bad, dir_bad;
    logic [NL-1:0] dir2;
    int            move_t[$];
    int            load_t[$];

    function automatic exp_t model(int lane, int mode, int val, int oor_step);
        exp_t e;
        int   cur = tap_m[lane];
        int   n, sgn;
        bit   abort;
        e.lane = lane; e.st = 0; e.nmov = 0; e.nload = 0; e.tap = cur;
        if (mode == 0) begin
            e.nload = 1; e.lat = 3; e.tap = INIT;
            return e;
        end
        if ((mode == 1 && val > MAXT) || (mode == 2 && cur + val > MAXT)
            || (mode == 3 && val > cur)) begin
            e.st = 2; e.lat = 2;
            return e;
        end
        sgn   = (mode == 2 || (mode == 1 && val > cur)) ? 1 : -1;
        n     = (mode == 1) ? ((val > cur) ? val - cur : cur - val) : val;
        abort = oor_step >= 0 && oor_step < n;
        e.nmov = abort ? oor_step + 1 : n;
        e.st   = abort ? 1 : 0;
        e.tap  = cur + sgn * (abort ? oor_step : n);
        e.lat  = 3 + e.nmov * STEP;
        return e;
    endfunction

    task automatic issue(input int lane, input int mode, input int val,
                         input int oor_step, input bit hold);
        exp_q.push_back(model(lane, mode, val, oor_step));
        @(negedge clk);
        req_lane = 2'(lane); req_mode = 2'(mode);
        req_value = TW'(val); req_valid = 1'b1;
        for (int i = 0; i < 50 && req_ready !== 1'b1; i++) @(negedge clk);
        cmp_n++;
        if (req_ready !== 1'b1) begin
            bad_n++;
            $display("FAIL handshake: ready=%b required 1", req_ready);
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    // Observe cycles T1.. after a handshake; stop at DONE, bound or stop_mv moves.
    task automatic collect(input int lane, input int oor_step,
                           input int maxc, input int stop_mv);
        logic [NL-1:0] oh;
        oh = NL'(1) << lane;
        done_t = -1; done_st = -1; done_ln = -1;
        pulse_bad = 0; dir_bad = 0; dir2 = '0;
        move_t.delete(); load_t.delete();
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if (k == 2) dir2 = dir;
            if (k > 2 && dir !== dir2) dir_bad++;
            if ((|mv) && (|ld)) pulse_bad++;
            if (|ld) begin
                load_t.push_back(k);
                if (ld !== oh) pulse_bad++;
            end
            if (|mv) begin
                move_t.push_back(k);
                if (mv !== oh) pulse_bad++;
                if (oor_step >= 0 && move_t.size() == oor_step + 1) oor[lane] = 1'b1;
                if (stop_mv > 0 && move_t.size() == stop_mv) return;
            end
            if (done === 1'b1) begin
                done_t = k; done_st = int'(done_status); done_ln = int'(done_lane);
                break;
            end else if (done_status !== 2'b00 || done_lane !== 2'b00) begin
                pulse_bad++;
            end
        end
        oor = '0;
    endtask

    task automatic test_reset;
        logic [NL*TW-1:0] exp_taps;
        for (int l = 0; l < NL; l++) exp_taps[l*TW +: TW] = TW'(INIT);
        arst = 1'b1;
        repeat (3) @(negedge clk);
        cmp_n++;
        if ({req_ready, busy, done, done_lane, done_status, ld, mv, dir} !== '0) begin
            bad_n++;
            $display("FAIL reset_outputs: ready=%b busy=%b done=%b ld=%b mv=%b dir=%b required all 0",
                     req_ready, busy, done, ld, mv, dir);
        end
        cmp_n++;
        if (tap_cur !== exp_taps) begin
            bad_n++;
            $display("FAIL reset_taps: got %h required %h", tap_cur, exp_taps);
        end
        arst = 1'b0;
        @(negedge clk);
        cmp_n++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad_n++;
            $display("FAIL reset_release: ready=%b busy=%b required 1/0", req_ready, busy);
        end
        for (int l = 0; l < NL; l++) tap_m[l] = INIT;
    endtask

    task automatic test_load;
        exp_t e;
        issue(2, 0, 0, -1, 1'b0);
        collect(2, -1, 40, 0);
        e = exp_q.pop_front();
        cmp_n++;
        if (done_t !== e.lat || done_st !== e.st || done_ln !== e.lane) begin
            bad_n++;
            $display("FAIL load_done: t=%0d st=%0d lane=%0d required t=%0d st=%0d lane=%0d",
                     done_t, done_st, done_ln, e.lat, e.st, e.lane);
        end
        cmp_n++;
        if (load_t.size() !== 1 || load_t[0] !== 2 || move_t.size() !== 0 || pulse_bad !== 0) begin
            bad_n++;
            $display("FAIL load_pulse: loads=%0d moves=%0d bad=%0d required 1 load at T2, 0 moves",
                     load_t.size(), move_t.size(), pulse_bad);
        end
        cmp_n++;
        if (int'(tap_cur[2*TW +: TW]) !== e.tap) begin
            bad_n++;
            $display("FAIL load_tap: got %0d required %0d", tap_cur[2*TW +: TW], e.tap);
        end
        tap_m[2] = e.tap;
    endtask

    task automatic test_abs;
        exp_t e;
        int   tbad;
        issue(0, 1, 4, -1, 1'b0);
        collect(0, -1, 100, 0);
        e = exp_q.pop_front();
        tbad = 0;
        for (int i = 0; i < move_t.size(); i++) if (move_t[i] !== 3 + i * STEP) tbad++;
        cmp_n++;
        if (done_t !== e.lat || done_st !== e.st || done_ln !== e.lane) begin
            bad_n++;
            $display("FAIL abs_done: t=%0d st=%0d lane=%0d required t=%0d st=%0d lane=%0d",
                     done_t, done_st, done_ln, e.lat, e.st, e.lane);
        end
        cmp_n++;
        if (move_t.size() !== e.nmov || tbad !== 0 || pulse_bad !== 0) begin
            bad_n++;
            $display("FAIL abs_moves: n=%0d late=%0d bad=%0d required n=%0d at T3/T6/T9",
                     move_t.size(), tbad, pulse_bad, e.nmov);
        end
        cmp_n++;
        if (dir2[0] !== 1'b1 || dir_bad !== 0) begin
            bad_n++;
            $display("FAIL abs_dir: dir_t2=%b changes=%0d required 1/0", dir2[0], dir_bad);
        end
        cmp_n++;
        if (int'(tap_cur[0 +: TW]) !== e.tap) begin
            bad_n++;
            $display("FAIL abs_tap: got %0d required %0d", tap_cur[0 +: TW], e.tap);
        end
        tap_m[0] = e.tap;
    endtask

    task automatic test_reject;
        exp_t e;
        issue(1, 3, 2, -1, 1'b0);
        collect(1, -1, 40, 0);
        e = exp_q.pop_front();
        cmp_n++;
        if (done_t !== e.lat || done_st !== e.st || done_ln !== e.lane) begin
            bad_n++;
            $display("FAIL reject_done: t=%0d st=%0d lane=%0d required t=%0d st=%0d lane=%0d",
                     done_t, done_st, done_ln, e.lat, e.st, e.lane);
        end
        cmp_n++;
        if (move_t.size() !== 0 || load_t.size() !== 0 || int'(tap_cur[1*TW +: TW]) !== e.tap) begin
            bad_n++;
            $display("FAIL reject_effect: moves=%0d loads=%0d tap=%0d required 0/0/%0d",
                     move_t.size(), load_t.size(), tap_cur[1*TW +: TW], e.tap);
        end
    endtask

    task automatic test_inc_oor;
        exp_t e;
        int   tbad;
        issue(3, 2, 5, 2, 1'b0);
        collect(3, 2, 100, 0);
        e = exp_q.pop_front();
        tbad = 0;
        for (int i = 0; i < move_t.size(); i++) if (move_t[i] !== 3 + i * STEP) tbad++;
        cmp_n++;
        if (done_t !== e.lat || done_st !== e.st || done_ln !== e.lane) begin
            bad_n++;
            $display("FAIL oor_done: t=%0d st=%0d lane=%0d required t=%0d st=%0d lane=%0d",
                     done_t, done_st, done_ln, e.lat, e.st, e.lane);
        end
        cmp_n++;
        if (move_t.size() !== e.nmov || tbad !== 0 || pulse_bad !== 0 || dir_bad !== 0) begin
            bad_n++;
            $display("FAIL oor_moves: n=%0d late=%0d bad=%0d dirchg=%0d required n=%0d",
                     move_t.size(), tbad, pulse_bad, dir_bad, e.nmov);
        end
        cmp_n++;
        if (int'(tap_cur[3*TW +: TW]) !== e.tap) begin
            bad_n++;
            $display("FAIL oor_tap: got %0d required %0d", tap_cur[3*TW +: TW], e.tap);
        end
        tap_m[3] = e.tap;
    endtask

    // Zero-step, full-scale and just-out-of-range requests.
    task automatic test_boundary;
        int   tbl[6][3] = '{'{1, 1, 1}, '{0, 2, 251}, '{0, 2, 1},
                            '{1, 2, 0}, '{0, 3, 255}, '{3, 3, 4}};
        exp_t e;
        int   tbad, ln;
        for (int r = 0; r < 6; r++) begin
            ln = tbl[r][0];
            issue(ln, tbl[r][1], tbl[r][2], -1, 1'b0);
            collect(ln, -1, 1000, 0);
            e = exp_q.pop_front();
            tbad = 0;
            for (int i = 0; i < move_t.size(); i++) if (move_t[i] !== 3 + i * STEP) tbad++;
            cmp_n++;
            if (done_t !== e.lat || done_st !== e.st || done_ln !== e.lane) begin
                bad_n++;
                $display("FAIL bound%0d_done: t=%0d st=%0d lane=%0d required t=%0d st=%0d lane=%0d",
                         r, done_t, done_st, done_ln, e.lat, e.st, e.lane);
            end
            cmp_n++;
            if (move_t.size() !== e.nmov || tbad !== 0 || pulse_bad !== 0 || dir_bad !== 0) begin
                bad_n++;
                $display("FAIL bound%0d_moves: n=%0d late=%0d bad=%0d dirchg=%0d required n=%0d",
                         r, move_t.size(), tbad, pulse_bad, dir_bad, e.nmov);
            end
            cmp_n++;
            if (int'(tap_cur[ln*TW +: TW]) !== e.tap) begin
                bad_n++;
                $display("FAIL bound%0d_tap: got %0d required %0d", r, tap_cur[ln*TW +: TW], e.tap);
            end
            tap_m[ln] = e.tap;
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        issue(1, 2, 2, -1, 1'b1);
        exp_q.push_back(model(2, 1, 5, -1));
        req_lane = 2'd2; req_mode = 2'd1; req_value = TW'(5);
        collect(1, -1, 100, 0);
        e = exp_q.pop_front();
        cmp_n++;
        if (done_t !== e.lat || done_st !== e.st || done_ln !== e.lane
            || move_t.size() !== e.nmov || pulse_bad !== 0) begin
            bad_n++;
            $display("FAIL b2b_first: t=%0d st=%0d lane=%0d n=%0d bad=%0d required t=%0d st=%0d lane=%0d n=%0d",
                     done_t, done_st, done_ln, move_t.size(), pulse_bad, e.lat, e.st, e.lane, e.nmov);
        end
        cmp_n++;
        if (int'(tap_cur[1*TW +: TW]) !== e.tap) begin
            bad_n++;
            $display("FAIL b2b_first_tap: got %0d required %0d", tap_cur[1*TW +: TW], e.tap);
        end
        tap_m[1] = e.tap;
        @(negedge clk);
        cmp_n++;
        if (req_ready !== 1'b1) begin
            bad_n++;
            $display("FAIL b2b_ready: got %b required 1 in cycle after DONE", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        collect(2, -1, 100, 0);
        e = exp_q.pop_front();
        cmp_n++;
        if (done_t !== e.lat || done_st !== e.st || done_ln !== e.lane
            || move_t.size() !== e.nmov || pulse_bad !== 0) begin
            bad_n++;
            $display("FAIL b2b_second: t=%0d st=%0d lane=%0d n=%0d bad=%0d required t=%0d st=%0d lane=%0d n=%0d",
                     done_t, done_st, done_ln, move_t.size(), pulse_bad, e.lat, e.st, e.lane, e.nmov);
        end
        cmp_n++;
        if (int'(tap_cur[2*TW +: TW]) !== e.tap) begin
            bad_n++;
            $display("FAIL b2b_second_tap: got %0d required %0d", tap_cur[2*TW +: TW], e.tap);
        end
        tap_m[2] = e.tap;
    endtask

    task automatic test_arst_mid;
        exp_t             e;
        int               start, n_done;
        logic [NL*TW-1:0] exp_taps;
        for (int l = 0; l < NL; l++) exp_taps[l*TW +: TW] = TW'(INIT);
        start = tap_m[0];
        issue(0, 1, start + 6, -1, 1'b0);
        collect(0, -1, 100, 3);
        e = exp_q.pop_front();
        cmp_n++;
        if (move_t.size() !== 3 || int'(tap_cur[0 +: TW]) !== start + 2) begin
            bad_n++;
            $display("FAIL arst_progress: moves=%0d tap=%0d required 3/%0d",
                     move_t.size(), tap_cur[0 +: TW], start + 2);
        end
        arst = 1'b1;
        #1;
        cmp_n++;
        if ({mv, ld, done, busy, req_ready, done_status} !== '0) begin
            bad_n++;
            $display("FAIL arst_outputs: mv=%b ld=%b done=%b busy=%b ready=%b required all 0",
                     mv, ld, done, busy, req_ready);
        end
        cmp_n++;
        if (tap_cur !== exp_taps) begin
            bad_n++;
            $display("FAIL arst_taps: got %h required %h (lane0 was %0d)", tap_cur, exp_taps, e.tap);
        end
        repeat (2) @(negedge clk);
        arst = 1'b0;
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || mv !== '0) n_done++;
        end
        cmp_n++;
        if (n_done !== 0 || req_ready !== 1'b1) begin
            bad_n++;
            $display("FAIL arst_after: stray_cycles=%0d ready=%b required 0/1", n_done, req_ready);
        end
        for (int l = 0; l < NL; l++) tap_m[l] = INIT;
    endtask

    initial begin
        test_reset();
        test_load();
        test_abs();
        test_reject();
        test_inc_oor();
        test_boundary();
        test_back_to_back();
        test_arst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", cmp_n);
        $fatal(1, "watchdog");
    end

endmodule
